// File: rtl/stopwatch_pkg.sv
// Shared time-field layout, limits and FSM encoding for the stopwatch core.
package stopwatch_pkg;
  localparam int CS_W   = 7;
  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;
  localparam int TIME_W = 24;

  localparam logic [CS_W-1:0]  CS_MAX  = 7'd99;
  localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;
  localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;

  typedef enum logic {ST_STOP = 1'b0, ST_RUN = 1'b1} state_e;

  typedef struct packed {
    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0]  min;
    logic [SEC_W-1:0]  sec;
    logic [CS_W-1:0]   cs;
  } time_t;
endpackage

// File: rtl/stopwatch_lap_fifo.sv
// Show-ahead lap FIFO; a push into a full FIFO succeeds when a pop frees a slot the same cycle.
module stopwatch_lap_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 24
)(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [WIDTH-1:0]           i_data,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0][WIDTH-1:0] r_mem;
  logic [AW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_cnt;
  logic w_push, w_pop;

  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == CW'(DEPTH));
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_data  = r_mem[r_rp];
  assign o_count = r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mem <= '0;
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (i_flush) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= i_data;
        r_wp        <= r_wp + 1'b1;
      end
      if (w_pop) r_rp <= r_rp + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end
endmodule

// File: rtl/stopwatch_lap_core.sv
// Stopwatch/timer core: centisecond divider, up/down field chain, RUN/STOP FSM and lap capture.
module stopwatch_lap_core
  import stopwatch_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int HOUR_MAX    = 24,
  parameter int LAP_DEPTH   = 4
)(
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           i_run_stop,
  input  logic                           i_clear,
  input  logic                           i_lap,
  input  logic                           i_dir,
  input  logic                           i_load,
  input  logic [TIME_W-1:0]              i_preset,
  input  logic                           i_lap_rd,
  output logic [TIME_W-1:0]              o_time,
  output logic                           o_running,
  output logic                           o_dir,
  output logic                           o_done,
  output logic [TIME_W-1:0]              o_lap_data,
  output logic                           o_lap_valid,
  output logic [$clog2(LAP_DEPTH+1)-1:0] o_lap_count,
  output logic                           o_lap_ovf
);
  localparam int DIV   = CLK_FREQ_HZ / 100;
  localparam int DIV_W = $clog2(DIV);

  state_e         r_state;
  logic [DIV_W-1:0] r_div;
  time_t          r_time, w_up, w_dn, w_base;
  logic           r_dir, r_done, r_ovf;
  logic           w_run, w_tick, w_clr, w_ld, w_go, w_zero_hit, w_push, w_full, w_empty;

  assign w_run      = (r_state == ST_RUN);
  assign w_tick     = w_run && (r_div == DIV_W'(DIV-1));
  assign w_clr      = !w_run && i_clear;
  assign w_ld       = !w_run && i_load && !i_clear;
  assign w_base     = w_clr ? time_t'('0) : (w_ld ? time_t'(i_preset) : r_time);
  // The start guard looks at the time after any same-cycle clear/load so a timer never starts at zero.
  assign w_go       = !w_run && i_run_stop && !(r_dir && (w_base == time_t'('0)));
  assign w_zero_hit = w_tick && r_dir && (w_dn == time_t'('0));
  assign w_push     = w_run && i_lap;

  always_comb begin
    w_up = r_time;
    if (r_time.cs != CS_MAX) w_up.cs = r_time.cs + 1'b1;
    else begin
      w_up.cs = '0;
      if (r_time.sec != SEC_MAX) w_up.sec = r_time.sec + 1'b1;
      else begin
        w_up.sec = '0;
        if (r_time.min != MIN_MAX) w_up.min = r_time.min + 1'b1;
        else begin
          w_up.min  = '0;
          w_up.hour = (r_time.hour == HOUR_W'(HOUR_MAX-1)) ? '0 : r_time.hour + 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_dn = r_time;
    if (r_time.cs != '0) w_dn.cs = r_time.cs - 1'b1;
    else begin
      w_dn.cs = CS_MAX;
      if (r_time.sec != '0) w_dn.sec = r_time.sec - 1'b1;
      else begin
        w_dn.sec = SEC_MAX;
        if (r_time.min != '0) w_dn.min = r_time.min - 1'b1;
        else begin
          w_dn.min  = MIN_MAX;
          w_dn.hour = (r_time.hour != '0) ? r_time.hour - 1'b1 : HOUR_W'(HOUR_MAX-1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_STOP;
      r_div   <= '0;
      r_time  <= '0;
      r_dir   <= 1'b0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_run) begin
        r_div <= w_tick ? '0 : r_div + 1'b1;
        if (w_tick) r_time <= r_dir ? w_dn : w_up;
        if (w_zero_hit) begin
          r_state <= ST_STOP;
          r_done  <= 1'b1;
        end else if (i_run_stop) begin
          r_state <= ST_STOP;
        end
        if (w_push && w_full && !i_lap_rd) r_ovf <= 1'b1;
      end else begin
        r_time <= w_base;
        if (w_clr || w_ld) r_div <= '0;
        if (w_clr) r_ovf <= 1'b0;
        // Direction is frozen on the start edge so the zero guard and the count agree.
        if (w_go) r_state <= ST_RUN;
        else      r_dir   <= i_dir;
      end
    end
  end

  stopwatch_lap_fifo #(.DEPTH(LAP_DEPTH), .WIDTH(TIME_W)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_flush (w_clr),
    .i_push  (w_push),
    .i_pop   (i_lap_rd),
    .i_data  (r_time),
    .o_data  (o_lap_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (o_lap_count)
  );

  assign o_time      = r_time;
  assign o_running   = w_run;
  assign o_dir       = r_dir;
  assign o_done      = r_done;
  assign o_lap_ovf   = r_ovf;
  assign o_lap_valid = !w_empty;
endmodule

// File: tb/tb_stopwatch_lap_core.sv
// Bench for stopwatch_lap_core: command table, directed corner sequences, random run vs. an integer model.
module tb_stopwatch_lap_core;
  localparam int DIV  = 10;
  localparam int TMAX = 24 * 360000;

  logic clk = 1'b0, reset = 1'b0;
  logic i_run_stop = 0, i_clear = 0, i_lap = 0, i_dir = 0, i_load = 0, i_lap_rd = 0;
  logic [23:0] i_preset = '0;
  logic [23:0] o_time, o_lap_data;
  logic o_running, o_dir, o_done, o_lap_valid, o_lap_ovf;
  logic [2:0] o_lap_count;

  stopwatch_lap_core #(.CLK_FREQ_HZ(1000), .HOUR_MAX(24), .LAP_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .i_run_stop(i_run_stop), .i_clear(i_clear), .i_lap(i_lap),
    .i_dir(i_dir), .i_load(i_load), .i_preset(i_preset), .i_lap_rd(i_lap_rd),
    .o_time(o_time), .o_running(o_running), .o_dir(o_dir), .o_done(o_done),
    .o_lap_data(o_lap_data), .o_lap_valid(o_lap_valid), .o_lap_count(o_lap_count),
    .o_lap_ovf(o_lap_ovf));

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  // Reference model: time kept as total centiseconds, laps in a queue.
  bit m_run, m_dir, m_done, m_ovf;
  int m_t, m_phase;
  logic [23:0] m_q[$];

  function automatic logic [23:0] pk(input int t);
    return {5'(t / 360000), 6'((t / 6000) % 60), 6'((t / 100) % 60), 7'(t % 100)};
  endfunction

  function automatic int upk(input logic [23:0] v);
    return int'(v[23:19]) * 360000 + int'(v[18:13]) * 6000 + int'(v[12:7]) * 100 + int'(v[6:0]);
  endfunction

  task automatic model_reset();
    m_run = 0; m_dir = 0; m_done = 0; m_ovf = 0; m_t = 0; m_phase = 0;
    m_q.delete();
  endtask

  task automatic model_edge();
    bit pop_ok, push_ok;
    pop_ok = i_lap_rd && (m_q.size() > 0);
    m_done = 0;
    if (m_run) begin
      push_ok = i_lap && (m_q.size() < 4 || pop_ok);
      if (i_lap && !push_ok) m_ovf = 1;
      if (pop_ok) void'(m_q.pop_front());
      if (push_ok) m_q.push_back(pk(m_t));
      m_phase++;
      if (m_phase == DIV) begin
        m_phase = 0;
        m_t = m_dir ? m_t - 1 : (m_t + 1) % TMAX;
        if (m_dir && m_t == 0) begin m_run = 0; m_done = 1; end
      end
      if (i_run_stop) m_run = 0;
    end else begin
      if (i_clear) begin
        m_t = 0; m_phase = 0; m_ovf = 0; m_q.delete();
      end else begin
        if (i_load) begin m_t = upk(i_preset); m_phase = 0; end
        if (pop_ok) void'(m_q.pop_front());
      end
      if (i_run_stop && !(m_dir && m_t == 0)) m_run = 1;
      else m_dir = i_dir;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    chk("m.time", 32'(o_time), 32'(pk(m_t)));
    chk("m.running", 32'(o_running), 32'(m_run));
    chk("m.dir", 32'(o_dir), 32'(m_dir));
    chk("m.done", 32'(o_done), 32'(m_done));
    chk("m.count", 32'(o_lap_count), 32'(m_q.size()));
    chk("m.ovf", 32'(o_lap_ovf), 32'(m_ovf));
    chk("m.valid", 32'(o_lap_valid), 32'(m_q.size() > 0));
    if (m_q.size() > 0) chk("m.lapdata", 32'(o_lap_data), 32'(m_q[0]));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_model();
    i_run_stop = 0; i_clear = 0; i_load = 0; i_lap = 0; i_lap_rd = 0;
  endtask

  typedef struct {
    bit rs, clr, ld, dir;
    int pre;
    int et;
    bit er, ed;
  } vec_t;
  vec_t tbl[10];

  int exp_laps[4] = '{5, 17, 30, 44};
  int lap_tg[5]   = '{5, 17, 30, 44, 60};

  initial begin
    int guard, dcnt, r;
    tbl[0] = '{0, 0, 1, 0, 372304, 372304, 0, 0};
    tbl[1] = '{0, 1, 1, 0, 500,    0,      0, 0};
    tbl[2] = '{0, 0, 1, 1, 5,      5,      0, 1};
    tbl[3] = '{0, 1, 0, 1, 0,      0,      0, 1};
    tbl[4] = '{1, 0, 0, 1, 0,      0,      0, 1};
    tbl[5] = '{1, 0, 1, 1, 5,      5,      1, 1};
    tbl[6] = '{0, 1, 0, 1, 0,      5,      1, 1};
    tbl[7] = '{0, 0, 1, 1, 77,     5,      1, 1};
    tbl[8] = '{1, 0, 0, 1, 0,      5,      0, 1};
    tbl[9] = '{0, 0, 0, 0, 0,      5,      0, 0};

    // Power-on reset state
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst.time", 32'(o_time), 0);
    chk("rst.running", 32'(o_running), 0);
    chk("rst.count", 32'(o_lap_count), 0);
    chk("rst.valid", 32'(o_lap_valid), 0);
    reset = 1'b1;

    // STOP-state command table
    for (int k = 0; k < 10; k++) begin
      i_run_stop = tbl[k].rs; i_clear = tbl[k].clr; i_load = tbl[k].ld;
      i_dir = tbl[k].dir; i_preset = pk(tbl[k].pre);
      step();
      chk($sformatf("tbl%0d.time", k), 32'(o_time), 32'(pk(tbl[k].et)));
      chk($sformatf("tbl%0d.running", k), 32'(o_running), 32'(tbl[k].er));
      chk($sformatf("tbl%0d.dir", k), 32'(o_dir), 32'(tbl[k].ed));
    end

    // One second of run, frozen, then resume
    i_clear = 1; step();
    i_run_stop = 1; step();
    repeat (999) step();
    i_run_stop = 1; step();
    chk("sec.time", 32'(o_time), 32'(pk(100)));
    chk("sec.running", 32'(o_running), 0);
    repeat (20) step();
    chk("sec.frozen", 32'(o_time), 32'(pk(100)));
    i_run_stop = 1; step();
    repeat (10) step();
    chk("sec.resume", 32'(o_time), 32'(pk(101)));
    i_run_stop = 1; step();

    // Lap capture and overflow
    i_clear = 1; step();
    i_run_stop = 1; step();
    for (int l = 0; l < 5; l++) begin
      guard = 0;
      while (o_time !== pk(lap_tg[l]) && guard < 2000) begin step(); guard++; end
      chk($sformatf("lap%0d.reached", l), 32'(guard < 2000), 1);
      i_lap = 1; step();
    end
    chk("lap.count", 32'(o_lap_count), 4);
    chk("lap.ovf", 32'(o_lap_ovf), 1);
    i_run_stop = 1; step();
    for (int l = 0; l < 4; l++) begin
      chk($sformatf("pop%0d.valid", l), 32'(o_lap_valid), 1);
      chk($sformatf("pop%0d.data", l), 32'(o_lap_data), 32'(pk(exp_laps[l])));
      i_lap_rd = 1; step();
    end
    chk("pop.empty", 32'(o_lap_valid), 0);
    i_lap_rd = 1; step();
    chk("pop.ignored", 32'(o_lap_count), 0);

    // Down-count to zero
    i_dir = 1; step();
    i_clear = 1; step();
    i_load = 1; i_preset = pk(5); step();
    i_run_stop = 1; step();
    dcnt = 0;
    repeat (49) begin step(); dcnt += int'(o_done); end
    chk("dn.time49", 32'(o_time), 32'(pk(1)));
    step(); dcnt += int'(o_done);
    chk("dn.zero", 32'(o_time), 0);
    chk("dn.done", 32'(o_done), 1);
    chk("dn.stop", 32'(o_running), 0);
    step(); dcnt += int'(o_done);
    i_run_stop = 1; step(); dcnt += int'(o_done);
    chk("dn.blocked", 32'(o_running), 0);
    chk("dn.onepulse", 32'(dcnt), 1);

    // Full wrap while counting up
    i_dir = 0; step();
    i_load = 1; i_preset = pk(TMAX - 1); step();
    i_run_stop = 1; step();
    repeat (9) step();
    chk("wrap.pre", 32'(o_time), 32'(pk(TMAX - 1)));
    step();
    chk("wrap.time", 32'(o_time), 0);
    chk("wrap.running", 32'(o_running), 1);
    i_run_stop = 1; step();

    // Asynchronous reset mid-run with two laps held
    i_clear = 1; step();
    i_run_stop = 1; step();
    i_lap = 1; step();
    repeat (12) step();
    i_lap = 1; step();
    repeat (3) step();
    chk("mid.count", 32'(o_lap_count), 2);
    #2 reset = 1'b0;
    #1;
    chk("ar.time", 32'(o_time), 0);
    chk("ar.running", 32'(o_running), 0);
    chk("ar.count", 32'(o_lap_count), 0);
    chk("ar.ovf", 32'(o_lap_ovf), 0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;

    // Random stimulus against the model
    for (int n = 0; n < 3000; n++) begin
      i_run_stop = ($urandom_range(0, 29) == 0);
      i_clear    = ($urandom_range(0, 39) == 0);
      i_load     = ($urandom_range(0, 29) == 0);
      i_lap      = ($urandom_range(0, 5) == 0);
      i_lap_rd   = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 39) == 0) i_dir = ~i_dir;
      r = int'($urandom_range(0, 3));
      if (r == 0)      i_preset = pk(int'($urandom_range(1, 200)));
      else if (r == 1) i_preset = pk(TMAX - 1 - int'($urandom_range(0, 100)));
      else             i_preset = pk(int'($urandom_range(0, TMAX - 1)));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
